fetch_decode_stage: RTL
=======================

Name: fetch_decode_stage

Overview:
- Fetch stage plus Fetch-to-Decode pipeline register of the 5-stage MIPS pipeline.
- Sits directly upstream of the control unit. It owns the program counter, drives the instruction-memory address, and latches the fetched word into the Decode stage.
- It splits the Decode-stage word into the op/Funct/register/immediate fields that feed the control unit and register file.
- Stall and flush come from the hazard unit and the Decode-stage branch resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  in  1  pipeline clock, rising-edge
reset  in  1  asynchronous, active-high reset
StallF  in  1  hold PCF this cycle
StallD  in  1  hold the Decode register this cycle
PCSrcD  in  1  branch taken in Decode; redirect fetch and flush Decode
PCBranchD  in  32  branch target computed in Decode
InstrF  in  32  instruction word from imem; combinational read of PCF
PCF  out  32  fetch address to imem
InstrD  out  32  instruction word in Decode
PCPlus4D  out  32  PC+4 of the instruction in Decode
opD  out  6  InstrD[31:26]
FunctD  out  6  InstrD[5:0]
RsD  out  5  InstrD[25:21]
RtD  out  5  InstrD[20:16]
RdD  out  5  InstrD[15:11]
ImmD  out  16  InstrD[15:0]
ValidD  out  1  Decode holds a real, non-flushed instruction
FetchCnt  out  32  performance counter (see Optional Feature)
StallCnt  out  32  performance counter
FlushCnt  out  32  performance counter

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - PCF=RESET_PC; InstrD=0 (sll $0 = nop); PCPlus4D=0; ValidD=0; all counters 0.
  - First edge after reset release fetches from RESET_PC.
- PCPlus4F = PCF + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). Combinational, internal.
- PC register, per rising edge:
  - StallF=1: PCF holds.
  - Else PCSrcD=1: PCF <= {PCBranchD[31:2],2'b00}. Low target bits are forced to zero.
  - Else: PCF <= PCPlus4F.
- Decode register, per rising edge:
  - StallD=1: InstrD, PCPlus4D, ValidD all hold. PCSrcD is ignored for the flush; clear happens only when enabled.
  - Else PCSrcD=1: flush. InstrD<=0, PCPlus4D<=0, ValidD<=0.
  - Else: InstrD<=InstrF, PCPlus4D<=PCPlus4F, ValidD<=1.
- Field outputs are combinational slices of InstrD, so zero latency from the register.
- Fetch-to-Decode latency is 1 cycle. No branch delay slot: the wrong-path instruction fetched alongside a taken branch is flushed.
- StallF=1 with StallD=0: PCF holds and Decode loads InstrF again (duplicate fetch is legal). The hazard unit never drives this; the behaviour is defined anyway.
- StallF=0 with StallD=1: PC advances and the fetched word is dropped. The hazard unit never drives this; the bench flags it as a protocol error.
- PCSrcD=1 with StallF=1: the redirect is lost. The hazard unit must keep PCSrcD valid until StallF drops.
- Imem is assumed zero-wait and combinational. No handshake.

Optional Feature:
Macro: FETCH_PERF_CNT_EN
- Defined:
  - FetchCnt increments on each edge where Decode loads with ValidD<=1.
  - StallCnt increments on each edge with StallD=1.
  - FlushCnt increments on each edge where the flush branch is taken.
  - All three saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: the three ports are tied to 32'h0 and no counter flops are synthesised. Pipeline behaviour is identical in both builds.

Test Plan:
1. Reset with RESET_PC=32'h0000_0040, then 3 free-running cycles, imem returning 32'h1111_0000+PCF → PCF 0x40,0x44,0x48,0x4C. InstrD=0x1111_0040 one cycle after PCF=0x40. PCPlus4D=0x44. ValidD rises on the first edge.
2. Assert PCSrcD=1 with PCBranchD=32'h0000_0103 for one cycle while PCF=0x50 → next PCF=0x100. InstrD=0, ValidD=0, PCPlus4D=0. The following cycle InstrD=mem[0x100], ValidD=1. FlushCnt=1 when the macro is on.
3. StallF=StallD=1 for 2 cycles at PCF=0x60 with InstrD=X → PCF stays 0x60 and InstrD stays X for both cycles. Release gives PCF=0x64. StallCnt=2.
4. StallD=1 and PCSrcD=1 together → no flush, InstrD holds. Next cycle StallD=0, PCSrcD=1 → flush occurs.
5. Force PCF=32'hFFFF_FFFC by branch, run 1 cycle → PCF=0, PCPlus4D=0 for that instruction.
6. Assert reset asynchronously mid-cycle during a stall → outputs reach reset values before the next edge. Counters return to 0. The fields decode InstrD=32'h0000_0020 as op=0, Funct=0x20, Rs=Rt=Rd=0.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: MIPS fetch stage and Fetch-to-Decode pipeline register.
// Ports: clk/reset (async, active-high); StallF/StallD/PCSrcD/PCBranchD from
// the hazard unit and branch resolution; InstrF/PCF to and from the imem;
// InstrD, PCPlus4D, ValidD and its decoded fields go to Decode. FetchCnt,
// StallCnt and FlushCnt are performance counters. They are built only when
// FETCH_PERF_CNT_EN is defined. Otherwise they read as zero.
module fetch_decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        PCSrcD,
   input  logic [31:0] PCBranchD,
   input  logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus4D,
   output logic [5:0]  opD,
   output logic [5:0]  FunctD,
   output logic [4:0]  RsD,
   output logic [4:0]  RtD,
   output logic [4:0]  RdD,
   output logic [15:0] ImmD,
   output logic        ValidD,
   output logic [31:0] FetchCnt,
   output logic [31:0] StallCnt,
   output logic [31:0] FlushCnt
);
   logic [31:0] pcPlus4F;
   logic        flushD;
   logic        loadD;
   assign pcPlus4F = PCF + 32'd4;
   // A stalled Decode register ignores the flush request.
   assign flushD = !StallD && PCSrcD;
   assign loadD = !StallD && !PCSrcD;
   always_ff @(posedge clk or posedge reset)
      if (reset) PCF <= RESET_PC;
      else if (!StallF) PCF <= PCSrcD ? (PCBranchD & ~32'd3) : pcPlus4F;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         InstrD   <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         InstrD   <= PCSrcD ? '0 : InstrF;
         PCPlus4D <= PCSrcD ? '0 : pcPlus4F;
         ValidD   <= !PCSrcD;
      end
   assign opD    = InstrD[31:26];
   assign RsD    = InstrD[25:21];
   assign RtD    = InstrD[20:16];
   assign RdD    = InstrD[15:11];
   assign ImmD   = InstrD[15:0];
   assign FunctD = InstrD[5:0];
`ifdef FETCH_PERF_CNT_EN
   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         FetchCnt <= '0;
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         FetchCnt <= FetchCnt + 32'(loadD && FetchCnt != '1);
         StallCnt <= StallCnt + 32'(StallD && StallCnt != '1);
         FlushCnt <= FlushCnt + 32'(flushD && FlushCnt != '1);
      end
`else
   logic unusedCnt;
   assign unusedCnt = loadD ^ flushD;
   assign FetchCnt = '0;
   assign StallCnt = '0;
   assign FlushCnt = '0;
`endif
endmodule
